// File: rtl/mac_lane_accum.sv
// Multi-lane signed multiply-accumulate engine with per-group saturation and ReLU.
// Three-stage pipeline (operand register, product, accumulate) with a single stall
// condition freezing every stage while a finished result waits for downstream.
module mac_lane_accum #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned ACC_LEN_MAX  = 9,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned SAT_EN       = 1,
  localparam int unsigned LenW        = $clog2(ACC_LEN_MAX + 1)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]     op1,
  input  logic [LANES*DATA_WIDTH-1:0]     op2,
  input  logic [LenW-1:0]                 acc_len,
  input  logic                            relu_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*RESULT_WIDTH-1:0]   result
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned AccW  = ProdW + $clog2(ACC_LEN_MAX);
  localparam int unsigned ExtW  = (AccW > RESULT_WIDTH) ? AccW : RESULT_WIDTH;
  // Signed output range expressed at the common comparison width.
  localparam logic signed [ExtW-1:0] RMax = {1'b0, {(ExtW-1){1'b1}}} >> (ExtW - RESULT_WIDTH);
  localparam logic signed [ExtW-1:0] RMin = ~RMax;

  logic stall;
  logic accept;

  // Group framing state
  logic [LenW-1:0] in_cnt_q;
  logic [LenW-1:0] grp_len_q;
  logic            grp_relu_q;
  logic [LenW-1:0] len_in;
  logic [LenW-1:0] beat_len;
  logic            beat_first;
  logic            beat_last;
  logic            beat_relu;

  // Stage 1
  logic                          s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
  logic [LANES*DATA_WIDTH-1:0]   s1_op1_q, s1_op2_q;
  logic signed [DATA_WIDTH-1:0]  lane_a [LANES];
  logic signed [DATA_WIDTH-1:0]  lane_b [LANES];
  logic signed [ProdW-1:0]       prod_d [LANES];

  // Stage 2
  logic                          s2_valid_q, s2_first_q, s2_last_q, s2_relu_q;
  logic signed [ProdW-1:0]       s2_prod_q [LANES];

  // Stage 3
  logic signed [AccW-1:0]        acc_q [LANES];
  logic signed [AccW-1:0]        sum [LANES];
  logic signed [ExtW-1:0]        sum_ext [LANES];
  logic [RESULT_WIDTH-1:0]       post_lane [LANES];
  logic [LANES*RESULT_WIDTH-1:0] post_res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rstn && !stall;
  assign accept   = in_valid && in_ready;

  // Beat framing: group length and ReLU are frozen on the first beat of a group.
  always_comb begin
    if (acc_len == '0) begin
      len_in = LenW'(1);
    end else if (acc_len > LenW'(ACC_LEN_MAX)) begin
      len_in = LenW'(ACC_LEN_MAX);
    end else begin
      len_in = acc_len;
    end
    beat_first = (in_cnt_q == '0);
    beat_len   = beat_first ? len_in : grp_len_q;
    beat_last  = (in_cnt_q == beat_len - LenW'(1));
    beat_relu  = beat_first ? relu_en : grp_relu_q;
  end

  // Input group counter and latched group attributes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_cnt_q   <= '0;
      grp_len_q  <= '0;
      grp_relu_q <= 1'b0;
    end else if (accept) begin
      in_cnt_q <= beat_last ? '0 : in_cnt_q + LenW'(1);
      if (beat_first) begin
        grp_len_q  <= len_in;
        grp_relu_q <= relu_en;
      end
    end
  end

  // Stage 1: register operands and group tags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_op1_q   <= '0;
      s1_op2_q   <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      s1_first_q <= beat_first;
      s1_last_q  <= beat_last;
      s1_relu_q  <= beat_relu;
      s1_op1_q   <= op1;
      s1_op2_q   <= op2;
    end
  end

  // Full-precision per-lane signed products.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_a[i] = s1_op1_q[i*DATA_WIDTH +: DATA_WIDTH];
      lane_b[i] = s1_op2_q[i*DATA_WIDTH +: DATA_WIDTH];
      prod_d[i] = ProdW'(lane_a[i]) * ProdW'(lane_b[i]);
    end
  end

  // Stage 2: register products and tags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_relu_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) s2_prod_q[i] <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_relu_q  <= s1_relu_q;
      for (int i = 0; i < LANES; i++) s2_prod_q[i] <= prod_d[i];
    end
  end

  // Accumulate, then saturate or truncate, then optional ReLU.
  always_comb begin
    post_res = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i]     = (s2_first_q ? '0 : acc_q[i]) + AccW'(s2_prod_q[i]);
      sum_ext[i] = ExtW'(sum[i]);
      if ((SAT_EN != 0) && (sum_ext[i] > RMax)) begin
        post_lane[i] = RMax[RESULT_WIDTH-1:0];
      end else if ((SAT_EN != 0) && (sum_ext[i] < RMin)) begin
        post_lane[i] = RMin[RESULT_WIDTH-1:0];
      end else begin
        post_lane[i] = sum_ext[i][RESULT_WIDTH-1:0];
      end
      if (s2_relu_q && post_lane[i][RESULT_WIDTH-1]) post_lane[i] = '0;
      post_res[i*RESULT_WIDTH +: RESULT_WIDTH] = post_lane[i];
    end
  end

  // Stage 3: accumulators and the registered result; a new last beat reloads
  // the result in the same cycle the previous one is taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      result    <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        for (int i = 0; i < LANES; i++) acc_q[i] <= s2_last_q ? '0 : sum[i];
        if (s2_last_q) result <= post_res;
      end
    end
  end

endmodule

// File: tb/tb_mac_lane_accum.sv
// Self-checking bench for mac_lane_accum: directed pins plus randomized traffic
// checked against a group-sum model for 32-bit, 16-bit saturating and 16-bit
// truncating instances driven in lockstep.
module tb_mac_lane_accum;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            relu_en = 1'b0;
  logic [L*DW-1:0] op1 = '0;
  logic [L*DW-1:0] op2 = '0;
  logic [LW-1:0]   acc_len = '0;
  logic            in_ready, in_ready_s, in_ready_t;
  logic            out_valid, out_valid_s, out_valid_t;
  logic [L*32-1:0] result;
  logic [L*16-1:0] result_s, result_t;

  int checks = 0;
  int failures = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  mac_lane_accum u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op1(op1), .op2(op2),
    .acc_len(acc_len), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  mac_lane_accum #(.RESULT_WIDTH(16), .SAT_EN(1)) u_sat16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s), .op1(op1), .op2(op2),
    .acc_len(acc_len), .relu_en(relu_en), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s)
  );

  mac_lane_accum #(.RESULT_WIDTH(16), .SAT_EN(0)) u_trn16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t), .op1(op1), .op2(op2),
    .acc_len(acc_len), .relu_en(relu_en), .out_valid(out_valid_t), .out_ready(out_ready),
    .result(result_t)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Output post-processing from the arithmetic definition.
  function automatic longint post(input longint s, input int rw, input bit sat, input bit relu);
    longint v, maxv, minv;
    maxv = (longint'(1) << (rw - 1)) - 1;
    minv = -(longint'(1) << (rw - 1));
    if (sat) begin
      v = (s > maxv) ? maxv : ((s < minv) ? minv : s);
    end else begin
      v = s & ((longint'(1) << rw) - 1);
      if (v > maxv) v = v - (longint'(1) << rw);
    end
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  // Reference model: group sums per lane, queued in completion order.
  int     m_cnt = 0;
  int     m_len = 1;
  bit     m_relu = 0;
  longint m_acc [L];
  longint sum_q [$];
  bit     relu_q [$];

  task automatic model_beat();
    if (m_cnt == 0) begin
      m_len  = (acc_len == 0) ? 1 : int'(acc_len);
      m_relu = relu_en;
      for (int i = 0; i < L; i++) m_acc[i] = 0;
    end
    for (int i = 0; i < L; i++)
      m_acc[i] += longint'($signed(op1[i*DW +: DW])) * longint'($signed(op2[i*DW +: DW]));
    m_cnt++;
    if (m_cnt == m_len) begin
      for (int i = 0; i < L; i++) sum_q.push_back(m_acc[i]);
      relu_q.push_back(m_relu);
      m_cnt = 0;
    end
  endtask

  bit              prev_stall = 0;
  logic [L*32-1:0] prev_r;
  logic [L*16-1:0] prev_rs, prev_rt;
  bit              cur_relu;
  longint          cur_sum;

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("in_ready", longint'(in_ready), longint'(rstn && !(out_valid && !out_ready)));
    if (prev_stall) begin
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_r32", longint'(result != prev_r), 0);
      chk("hold_sat16", longint'(result_s != prev_rs), 0);
      chk("hold_trn16", longint'(result_t != prev_rt), 0);
    end
    if (!rstn) begin
      m_cnt = 0;
      sum_q.delete();
      relu_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (relu_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          cur_relu = relu_q.pop_front();
          for (int i = 0; i < L; i++) begin
            cur_sum = sum_q.pop_front();
            chk($sformatf("r32_lane%0d", i), longint'($signed(result[i*32 +: 32])),
                post(cur_sum, 32, 1'b1, cur_relu));
            chk($sformatf("sat16_lane%0d", i), longint'($signed(result_s[i*16 +: 16])),
                post(cur_sum, 16, 1'b1, cur_relu));
            chk($sformatf("trn16_lane%0d", i), longint'($signed(result_t[i*16 +: 16])),
                post(cur_sum, 16, 1'b0, cur_relu));
          end
        end
        n_out++;
      end
      if (in_valid && in_ready) model_beat();
    end
    prev_stall = rstn && out_valid && !out_ready;
    prev_r  = result;
    prev_rs = result_s;
    prev_rt = result_t;
  end

  function automatic logic [L*DW-1:0] rep(input logic [DW-1:0] v);
    return {L{v}};
  endfunction

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                           input int len, input bit relu);
    int n;
    n = 0;
    op1 = a;
    op2 = b;
    acc_len = len[LW-1:0];
    relu_en = relu;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for a result and pin every lane of all three instances to literals.
  task automatic pin(input string nm, input longint e32, input longint es, input logic [15:0] et);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk({nm, "_valid"}, longint'(out_valid), 1);
    for (int i = 0; i < L; i++) begin
      chk({nm, "_r32"}, longint'($signed(result[i*32 +: 32])), e32);
      chk({nm, "_sat16"}, longint'($signed(result_s[i*16 +: 16])), es);
      chk({nm, "_trn16"}, longint'(result_t[i*16 +: 16]), longint'(et));
    end
    @(posedge clk);
    #1;
  endtask

  bit rnd_on = 0;
  int base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_result", longint'(result != '0 || result_s != '0 || result_t != '0), 0);

    // 1: single-beat group, latency and one-cycle result
    send_beat({24'h0, 8'h80}, {24'h0, 8'h80}, 1, 1'b0);
    @(negedge clk); chk("t1_lat_c1", longint'(out_valid), 0);
    @(negedge clk); chk("t1_lat_c2", longint'(out_valid), 0);
    @(negedge clk); chk("t1_lat_c3", longint'(out_valid), 1);
    chk("t1_lane0_r32", longint'($signed(result[31:0])), 16384);
    chk("t1_lane0_sat16", longint'($signed(result_s[15:0])), 16384);
    chk("t1_lane0_trn16", longint'($signed(result_t[15:0])), 16384);
    chk("t1_lane1_r32", longint'($signed(result[63:32])), 0);
    @(negedge clk); chk("t1_one_cycle", longint'(out_valid), 0);
    @(posedge clk); #1;

    // 2: nine beats of 127 x -128 per lane
    for (int k = 0; k < 9; k++) send_beat(rep(8'd127), rep(8'h80), 9, 1'b0);
    pin("t2", -146304, -32768, 16'hC480);

    // 3: ReLU sampled per group
    for (int k = 0; k < 2; k++) send_beat(rep(8'hFB), rep(8'd5), 2, 1'b1);
    pin("t3_relu", 0, 0, 16'h0000);
    for (int k = 0; k < 2; k++) send_beat(rep(8'hFB), rep(8'd5), 2, 1'b0);
    pin("t3_norelu", -50, -50, 16'hFFCE);

    // 4: streamed groups with a 10-cycle downstream stall
    base = n_out;
    fork
      begin
        for (int k = 0; k < 12; k++) send_beat($urandom(), $urandom(), 3, 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 60);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 60 && n_out < base + 4; n++) @(posedge clk);
    chk("t4_results", longint'(n_out - base), 4);
    #1;

    // 5: reset mid-group discards partial sums
    send_beat(rep(8'd7), rep(8'd9), 4, 1'b0);
    send_beat(rep(8'd7), rep(8'd9), 4, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("t5_out_valid", longint'(out_valid), 0);
    chk("t5_result", longint'(result != '0 || result_s != '0 || result_t != '0), 0);
    for (int k = 0; k < 4; k++) send_beat(rep(8'd2), rep(8'd3), 4, 1'b0);
    pin("t5", 24, 24, 16'd24);

    // 6: zero length acts as one; mid-group length changes are ignored
    send_beat(rep(8'd4), rep(8'd5), 0, 1'b0);
    pin("t6_len0", 20, 20, 16'd20);
    send_beat(rep(8'd1), rep(8'd1), 3, 1'b0);
    send_beat(rep(8'd2), rep(8'd2), 1, 1'b0);
    send_beat(rep(8'd3), rep(8'd3), 0, 1'b0);
    pin("t6_midgrp", 14, 14, 16'd14);

    // Randomized traffic with random backpressure
    rnd_on = 1;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          send_beat($urandom(), $urandom(), int'($urandom_range(0, 9)),
                    bit'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;

    // Flush a trailing partial group so every queued result drains.
    for (int k = 0; k < 9 && m_cnt != 0; k++) send_beat($urandom(), $urandom(), 1, 1'b0);
    for (int n = 0; n < 100 && (relu_q.size() != 0 || out_valid); n++) @(posedge clk);
    #1;
    chk("drain_empty", longint'(relu_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
